// File: rtl/lidar_rx_sequencer.sv
// Oversampled UART receiver for the LD06 LiDAR line plus packet framing tracker.
// State | meaning: IDLE wait for low line | START verify start bit | DATA shift 8 bits | STOP check stop bit
module lidar_rx_sequencer #(
  parameter int         TICKS_PER_BIT = 32,
  parameter int         SAMPLE_POINT  = 16,
  parameter int         PKT_BYTES     = 47,
  parameter logic [7:0] HEADER        = 8'h54
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx_in,
  output logic       latch,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       pkt_start,
  output logic       pkt_done,
  output logic [5:0] byte_idx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [5:0] TICK_LAST   = 6'(TICKS_PER_BIT - 1);
  localparam logic [5:0] TICK_SAMPLE = 6'(SAMPLE_POINT);
  localparam logic [5:0] PKT_LAST    = 6'(PKT_BYTES - 1);

  state_t     state_q, state_d;
  logic [5:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] cnt_q, cnt_d;
  logic       latch_q, latch_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       pkt_start_q, pkt_start_d;
  logic       pkt_done_q, pkt_done_d;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    latch_d      = 1'b0;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_done_d   = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_in) begin
            state_d = START;
            tick_d  = 6'd0;
          end
        end
        START: begin
          if (tick_q == TICK_SAMPLE && rx_in) begin
            state_d = IDLE;
            tick_d  = 6'd0;
          end else if (tick_q == TICK_LAST) begin
            state_d = DATA;
            tick_d  = 6'd0;
            bit_d   = 3'd0;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
        DATA: begin
          if (tick_q == TICK_SAMPLE) begin
            latch_d = 1'b1;
            shift_d = {rx_in, shift_q[7:1]};
          end
          if (tick_q == TICK_LAST) begin
            tick_d = 6'd0;
            if (bit_q == 3'd7) begin
              state_d = STOP;
              bit_d   = 3'd0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
        STOP: begin
          if (tick_q == TICK_SAMPLE) begin
            state_d = IDLE;
            tick_d  = 6'd0;
            if (rx_in) begin
              rx_byte_d    = shift_q;
              byte_valid_d = 1'b1;
              // Count 0 means hunting for the header; anything else is discarded.
              if (cnt_q == 6'd0) begin
                if (shift_q == HEADER) begin
                  idx_d       = 6'd0;
                  pkt_start_d = 1'b1;
                  cnt_d       = 6'd1;
                end
              end else begin
                idx_d = cnt_q;
                if (cnt_q == PKT_LAST) begin
                  pkt_done_d = 1'b1;
                  cnt_d      = 6'd0;
                end else begin
                  cnt_d = cnt_q + 6'd1;
                end
              end
            end else begin
              frame_err_d = 1'b1;
              cnt_d       = 6'd0;
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_q       <= 6'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      idx_q        <= 6'd0;
      cnt_q        <= 6'd0;
      latch_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      latch_q      <= latch_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      pkt_start_q  <= pkt_start_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign latch      = latch_q;
  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign pkt_start  = pkt_start_q;
  assign pkt_done   = pkt_done_q;
  assign byte_idx   = idx_q;

endmodule

// File: doc/lidar_rx_sequencer.md
LIDAR_RX_SEQUENCER -- requirements
Module: lidar_rx_sequencer

Interface
REQ-001 Parameter TICKS_PER_BIT, default 32: oversample ticks per serial bit (legal range 8..64).
REQ-002 Parameter SAMPLE_POINT, default 16: tick index within a bit at which the line is sampled (1..TICKS_PER_BIT-2).
REQ-003 Parameter PKT_BYTES, default 47: bytes per LiDAR packet, header byte included.
REQ-004 Parameter HEADER, default 8'h54: required first byte of a packet.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high system reset.
REQ-007 baud_tick  input  1  one-clk oversample strobe, TICKS_PER_BIT per bit period.
REQ-008 rx_in  input  1  serial line from the LD06 sensor, already synchronised to clk, idle high.
REQ-009 latch  output  1  one-clk pulse at each data-bit sample point; drives the oversampler capture flop.
REQ-010 rx_byte  output  8  last received byte, LSB first on the line.
REQ-011 byte_valid  output  1  one-clk pulse: rx_byte updated with a correctly framed byte.
REQ-012 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-013 pkt_start  output  1  one-clk pulse: HEADER accepted as packet byte 0.
REQ-014 pkt_done  output  1  one-clk pulse: byte PKT_BYTES-1 of a packet accepted.
REQ-015 byte_idx  output  6  index of rx_byte within the current packet (0..PKT_BYTES-1).

Function
REQ-016 The block SHALL implement states IDLE, START, DATA, STOP; tick_cnt (6 bits) and bit_cnt (3 bits) advance only on clk edges where baud_tick=1.
REQ-017 IDLE: on baud_tick with rx_in=0, go START with tick_cnt=0; otherwise remain.
REQ-018 START: at tick_cnt==SAMPLE_POINT, if rx_in=1, return to IDLE (glitch reject) with no output pulse.
REQ-019 START: at tick_cnt==TICKS_PER_BIT-1, clear tick_cnt and bit_cnt and go DATA.
REQ-020 DATA: at tick_cnt==SAMPLE_POINT, assert latch for one clk and shift rx_in into the MSB of an internal shift register (LSB-first reception).
REQ-021 DATA: at tick_cnt==TICKS_PER_BIT-1 with bit_cnt==7, go STOP; otherwise increment bit_cnt and clear tick_cnt.
REQ-022 STOP: at tick_cnt==SAMPLE_POINT, go IDLE in the same cycle; if rx_in=1, load rx_byte and pulse byte_valid; if rx_in=0, pulse frame_err and leave rx_byte unchanged.
REQ-023 latch SHALL pulse exactly 8 times per received frame and never in IDLE, START or STOP.
REQ-024 Packet tracking: while the packet count is 0, a valid byte equal to HEADER sets byte_idx=0, pulses pkt_start and sets the count to 1; a valid non-HEADER byte is discarded (no pkt_start, count stays 0).
REQ-025 While the packet count is k in 1..PKT_BYTES-1, a valid byte sets byte_idx=k and increments the count; when k==PKT_BYTES-1, pkt_done pulses with that byte_valid and the count returns to 0.
REQ-026 byte_idx SHALL change only in the cycle byte_valid is asserted.
REQ-027 A frame_err SHALL abort the current packet: count forced to 0, no pkt_done; the next HEADER restarts tracking.
REQ-028 All pulse outputs SHALL be registered, zero latency relative to the qualifying clk edge, and never wider than one clk.
REQ-029 When baud_tick is held 0, all state and outputs SHALL freeze apart from pulses returning to 0.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, tick_cnt=0, bit_cnt=0, packet count=0, rx_byte=8'h00, byte_idx=0, and latch, byte_valid, frame_err, pkt_start, pkt_done=0.
REQ-031 Reset asserted mid-frame or mid-packet SHALL discard the partial frame/packet; after release the block waits in IDLE for a new falling edge.

Verification
REQ-032 Byte 8'h54 at 32 ticks/bit, idle high after -> 8 latch pulses at bit tick 16, byte_valid with rx_byte=8'h54, pkt_start, byte_idx=0.
REQ-033 Full 47-byte packet 8'h54, 8'h2C, 45 arbitrary bytes -> 47 byte_valid pulses, byte_idx 0..46, one pkt_done coincident with the 47th byte_valid.
REQ-034 rx_in low for 10 ticks then high -> START aborts at tick 16, no latch, no byte_valid, state IDLE.
REQ-035 Byte 8'hA5 with stop bit held low -> 8 latch pulses, frame_err pulse, no byte_valid, rx_byte unchanged, packet count 0.
REQ-036 Byte 8'h12 while count=0 -> byte_valid, rx_byte=8'h12, no pkt_start, byte_idx stays 0.
REQ-037 reset asserted during bit 4 of a byte in packet byte 20 -> outputs cleared asynchronously; a subsequent 8'h54 yields pkt_start with byte_idx=0.
